ascon_ti_sbox_sched: RTL
========================

Name: ascon_ti_sbox_sched

Overview:
- Sequences the 3-share threshold-implementation (TI) Ascon substitution layer over the full 320-bit state (x0..x4, 64 bits each), held as three 320-bit shares.
- Processes P columns per cycle. Column j is bit j of x0..x4, with x0 as the MSB of the 5-bit S-box input.
- A register stage after the shared S-box gives TI glitch isolation.
- Sits between the permutation's round-constant addition and the linear diffusion layer. Driven by the permutation round FSM via a start/done handshake.

Parameters:
- COLS_PER_CYC, 8, columns substituted per cycle; legal values 1, 2, 4, 8, 16, 32, 64 (elaboration error otherwise).
- NUM_STEPS, 64/COLS_PER_CYC, derived localparam; column-group count.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- s0_in  input  320  share 0 of state, {x0,x1,x2,x3,x4}, x0 in [319:256]
- s1_in  input  320  share 1, same layout
- s2_in  input  320  share 2, same layout
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  single-cycle pulse when results are valid
- s0_out  output  320  substituted share 0
- s1_out  output  320  substituted share 1
- s2_out  output  320  substituted share 2

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; column counter cleared.
  - busy=0, done=0, s0_out/s1_out/s2_out=0, pipeline register cleared.
- FSM states:
  - IDLE: on start=1, latch s*_in into three 320-bit working registers, set counter=0, go to RUN. Otherwise hold.
  - RUN: each cycle, apply the shared S-box to the columns counter*P .. counter*P+P-1 of the working registers; the result goes to the pipeline register. Counter increments. When counter==NUM_STEPS-1 is issued, go to DRAIN.
  - DRAIN: the final pipeline register is written back; go to DONE.
  - DONE: done=1 for this single cycle; go to IDLE.
- Write-back: the pipeline register output for group g is written into the working registers one cycle after issue. Reads of group g+1 are unaffected because groups are disjoint.
- Latency: start accepted at cycle 0; done asserted at cycle NUM_STEPS+2 (10 cycles at P=8, 66 cycles at P=1).
- busy is high in RUN and DRAIN; low in IDLE and DONE.
- s*_out continuously mirror the working registers. They are architecturally valid at done and hold until the next accepted start.
- start while not in IDLE is ignored (no queuing). start in the DONE cycle is ignored.
- s*_in are sampled only in the start cycle; changes afterwards have no effect.
- Share semantics:
  - Output share k is computed only from input shares ≠ k, per TI non-completeness.
  - Shared functions implement Ascon S(x): S(0)=0x04, S(0x1F)=0x17.
  - The unshared output is s0_out^s1_out^s2_out.
  - The constant-1 term is confined to the x2 equation of share 1.
- Reset asserted mid-RUN aborts with no done pulse; outputs read zero afterwards.
- The counter width is max(1,$clog2(NUM_STEPS)), with no wrap-around beyond NUM_STEPS-1.

Optional Feature:
- Macro: ASCON_TI_REMASK_EN.
- When defined:
  - Adds input rnd (2*5*COLS_PER_CYC bits).
  - Each processed column's pipeline-register contents are refreshed: share0 ^= r_a, share1 ^= r_b, share2 ^= r_a^r_b.
  - The unshared value is unchanged; rnd is sampled every RUN cycle.
- When undefined: no rnd port; shares are written without refresh. Timing is identical in both modes.

Decomposition:
- Shared package ascon_ti_pkg holds:
  - localparams STATE_W=320, WORD_W=64, NUM_SHARES=3;
  - FSM state enum (IDLE, RUN, DRAIN, DONE);
  - the unmasked S-box lookup function used by benches.
- Sub-module: ascon_ti_sbox_col. It is combinational and produces the full 3-share 5-bit output for one column. It is instantiated COLS_PER_CYC times by a generate loop.

Test Plan:
- All-zero shares, start → done at cycle 10 (P=8). Unshared result: x2 word = 64'hFFFF_FFFF_FFFF_FFFF, x0/x1/x3/x4 = 0.
- s0_in=all ones, s1_in=s2_in=0 → unshared result: x0=x2=x3=x4=all ones, x1=0.
- Random shares (1000 vectors, P=1 and P=64 builds) → XOR of outputs equals the per-column S-box of the XOR of inputs. done at cycles 66 and 3 respectively.
- Second start pulsed during RUN → ignored; exactly one done. Outputs equal the first operation's result.
- rst asserted at cycle 4 of RUN → busy=0, done never pulses, outputs 0. A fresh start then completes normally.
- With ASCON_TI_REMASK_EN and nonzero rnd → individual shares differ from the non-remask build, while the unshared result is identical.

Source files
------------

// File: rtl/ascon_ti_pkg.sv
// Shared constants, FSM encoding and the unmasked Ascon S-box reference
// used by the 3-share TI substitution-layer scheduler and its benches.
package ascon_ti_pkg;
    localparam int STATE_W    = 320;
    localparam int WORD_W     = 64;
    localparam int NUM_SHARES = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Input/output bit 4 is x0, bit 0 is x4.
    localparam logic [4:0] SBOX_LUT [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [4:0] ascon_sbox(input logic [4:0] x);
        return SBOX_LUT[x];
    endfunction
endpackage

// File: rtl/ascon_ti_sbox_col.sv
// Combinational 3-share TI Ascon S-box for one column. Output share k only
// sees input shares k+1 and k+2; the constant-1 (x2 inversion) lives in share 1.
module ascon_ti_sbox_col
    import ascon_ti_pkg::*;
(
    input  logic [4:0] i_s0,
    input  logic [4:0] i_s1,
    input  logic [4:0] i_s2,
    output logic [4:0] o_s0,
    output logic [4:0] o_s1,
    output logic [4:0] o_s2
);
    // Internal vectors are indexed [i] = x_i, the reverse of the port bit order.
    logic [NUM_SHARES-1:0][4:0] w_x, w_a, w_c, w_y, w_out;
    logic [NUM_SHARES-1:0][4:0] w_in;

    assign w_in = {i_s2, i_s1, i_s0};

    always_comb begin
        w_x   = '0;
        w_a   = '0;
        w_c   = '0;
        w_y   = '0;
        w_out = '0;
        for (int s = 0; s < NUM_SHARES; s++) begin
            for (int i = 0; i < 5; i++) w_x[s][i] = w_in[s][4-i];
            w_a[s]    = w_x[s];
            w_a[s][0] = w_x[s][0] ^ w_x[s][4];
            w_a[s][4] = w_x[s][4] ^ w_x[s][3];
            w_a[s][2] = w_x[s][2] ^ w_x[s][1];
        end
        // chi: y_i = a_i ^ a_{i+2} ^ a_{i+1}a_{i+2}, cross products split so share k skips share k
        for (int k = 0; k < NUM_SHARES; k++) begin
            for (int i = 0; i < 5; i++) begin
                w_c[k][i] = w_a[(k+1)%NUM_SHARES][i]
                          ^ w_a[(k+1)%NUM_SHARES][(i+2)%5]
                          ^ (w_a[(k+1)%NUM_SHARES][(i+1)%5] & w_a[(k+1)%NUM_SHARES][(i+2)%5])
                          ^ (w_a[(k+1)%NUM_SHARES][(i+1)%5] & w_a[(k+2)%NUM_SHARES][(i+2)%5])
                          ^ (w_a[(k+2)%NUM_SHARES][(i+1)%5] & w_a[(k+1)%NUM_SHARES][(i+2)%5]);
            end
            w_y[k]    = w_c[k];
            w_y[k][1] = w_y[k][1] ^ w_y[k][0];
            w_y[k][0] = w_y[k][0] ^ w_y[k][4];
            w_y[k][3] = w_y[k][3] ^ w_y[k][2];
            if (k == 1) w_y[k][2] = ~w_y[k][2];
            for (int i = 0; i < 5; i++) w_out[k][4-i] = w_y[k][i];
        end
    end

    assign o_s0 = w_out[0];
    assign o_s1 = w_out[1];
    assign o_s2 = w_out[2];
endmodule

// File: rtl/ascon_ti_sbox_sched.sv
// Column-group scheduler for the 3-share TI Ascon substitution layer, with a
// glitch-isolating register after the S-boxes. ASCON_TI_REMASK_EN adds share refresh via rnd.
module ascon_ti_sbox_sched
    import ascon_ti_pkg::*;
#(
    parameter int COLS_PER_CYC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] s0_in,
    input  logic [STATE_W-1:0] s1_in,
    input  logic [STATE_W-1:0] s2_in,
`ifdef ASCON_TI_REMASK_EN
    input  logic [2*5*COLS_PER_CYC-1:0] rnd,
`endif
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] s0_out,
    output logic [STATE_W-1:0] s1_out,
    output logic [STATE_W-1:0] s2_out
);
    localparam int P         = COLS_PER_CYC;
    localparam int NUM_STEPS = WORD_W / P;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    if (P < 1 || P > WORD_W || (P & (P - 1)) != 0) begin : g_bad_cols
        $error("COLS_PER_CYC must be a power of two in 1..64");
    end

    state_e                                  r_state;
    logic [CNT_W-1:0]                        r_cnt, r_wcnt;
    logic                                    r_wvld;
    logic [NUM_SHARES-1:0][4:0][WORD_W-1:0]  r_w;     // [s][4] is x0
    logic [NUM_SHARES-1:0][4:0][P-1:0]       r_pipe;
    logic [NUM_SHARES-1:0][P-1:0][4:0]       w_col_in, w_col_out, w_mask;
    logic [5:0]                              w_rbase, w_wbase;

    assign w_rbase = 6'(r_cnt) * 6'(P);
    assign w_wbase = 6'(r_wcnt) * 6'(P);

    always_comb begin
        w_col_in = '0;
        for (int s = 0; s < NUM_SHARES; s++)
            for (int c = 0; c < P; c++)
                for (int b = 0; b < 5; b++)
                    w_col_in[s][c][b] = r_w[s][b][w_rbase + 6'(c)];
    end

    for (genvar c = 0; c < P; c++) begin : g_col
        ascon_ti_sbox_col u_col (
            .i_s0 (w_col_in[0][c]),
            .i_s1 (w_col_in[1][c]),
            .i_s2 (w_col_in[2][c]),
            .o_s0 (w_col_out[0][c]),
            .o_s1 (w_col_out[1][c]),
            .o_s2 (w_col_out[2][c])
        );
    end

`ifdef ASCON_TI_REMASK_EN
    // Refresh keeps the XOR of the three shares unchanged.
    always_comb begin
        w_mask = '0;
        for (int c = 0; c < P; c++) begin
            w_mask[0][c] = rnd[5*c +: 5];
            w_mask[1][c] = rnd[5*P + 5*c +: 5];
            w_mask[2][c] = rnd[5*c +: 5] ^ rnd[5*P + 5*c +: 5];
        end
    end
`else
    assign w_mask = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wcnt  <= '0;
            r_wvld  <= 1'b0;
            r_pipe  <= '0;
            r_w     <= '0;
        end else begin
            r_wvld <= (r_state == RUN);
            r_wcnt <= r_cnt;
            if (r_state == RUN)
                for (int s = 0; s < NUM_SHARES; s++)
                    for (int c = 0; c < P; c++)
                        for (int b = 0; b < 5; b++)
                            r_pipe[s][b][c] <= w_col_out[s][c][b] ^ w_mask[s][c][b];
            // Groups are disjoint, so writing back group g never disturbs the read of g+1.
            if (r_wvld)
                for (int s = 0; s < NUM_SHARES; s++)
                    for (int b = 0; b < 5; b++)
                        r_w[s][b][w_wbase +: P] <= r_pipe[s][b];
            case (r_state)
                IDLE: if (start) begin
                    r_w[0]  <= s0_in;
                    r_w[1]  <= s1_in;
                    r_w[2]  <= s2_in;
                    r_cnt   <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    if (r_cnt == CNT_W'(NUM_STEPS - 1)) r_state <= DRAIN;
                    else                                r_cnt   <= r_cnt + CNT_W'(1);
                end
                DRAIN:   r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = (r_state == RUN) || (r_state == DRAIN);
    assign done   = (r_state == DONE);
    assign s0_out = r_w[0];
    assign s1_out = r_w[1];
    assign s2_out = r_w[2];
endmodule
